// File: rtl/beta_muldiv.sv
// Iterative multiply/divide unit for the Beta datapath: fixed WIDTH+3 cycle latency
// for every operation, shift-add multiply and restoring divide sharing one accumulator.
module beta_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MOD  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    apply_sign = neg ? (~mag + WIDTH'(1)) : mag;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    magnitude = apply_sign(v, v[WIDTH-1]);
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;     // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] b_q, b_d;     // multiplier, or divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d; // product, or partial remainder
  logic             sa_q, sa_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic             is_signed_div;
  logic             div_by_zero;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign is_signed_div = (op_q == OP_DIV) || (op_q == OP_MOD);
  assign div_by_zero   = (op_q != OP_MUL) && (b_q == '0);

  // Next partial remainder brings down the next dividend bit, MSB first.
  assign rem_shift = {acc_q, a_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, b_q};

  // A zero divisor naturally yields all-ones quotient magnitude; the override keeps
  // it all-ones even when the operand signs would otherwise negate it.
  assign quo_fix = div_by_zero ? '1 : apply_sign(a_q, neg_q);
  assign rem_fix = apply_sign(acc_q, sa_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sa_d     = sa_q;
    neg_d    = neg_q;
    result_d = result_q;
    dz_d     = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        if (is_signed_div) begin
          a_d   = magnitude(a_q);
          b_d   = magnitude(b_q);
          sa_d  = a_q[WIDTH-1];
          neg_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        end else begin
          sa_d  = 1'b0;
          neg_d = 1'b0;
        end
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        if (op_q == OP_MUL) begin
          if (b_q[0]) begin
            acc_d = acc_q + a_q;
          end
          a_d = {a_q[WIDTH-2:0], 1'b0};
          b_d = {1'b0, b_q[WIDTH-1:1]};
        end else if (rem_ge) begin
          // True difference is below the divisor, so WIDTH bits hold it exactly.
          acc_d = rem_shift[WIDTH-1:0] - b_q;
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        case (op_q)
          OP_MUL:  result_d = acc_q;
          OP_MOD:  result_d = rem_fix;
          default: result_d = quo_fix;
        endcase
        dz_d    = div_by_zero;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
    sa_q  <= sa_d;
    neg_q <= neg_d;
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_beta_muldiv.sv
// Scoreboard bench for beta_muldiv: stimulus pushes model results, a negedge
// monitor pops and compares result, dz and done latency on every done pulse.
`timescale 1ns/1ps
module tb_beta_muldiv;

  localparam int W = 32;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MOD  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         dz;

  beta_muldiv #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .dz      (dz)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  logic [31:0] cyc = '0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    logic [31:0]  cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic with the edge cases spelled out.
  function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                       input logic [W-1:0] y);
    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic signed [W-1:0] r;
    logic                ovf;
    xs  = x;
    ys  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      OP_MUL: begin
        r = xs * ys;
        return {1'b0, r};
      end
      OP_DIV: begin
        if (y == '0) return {1'b1, 32'hFFFF_FFFF};
        if (ovf) return {1'b0, 32'h8000_0000};
        r = xs / ys;
        return {1'b0, r};
      end
      OP_MOD: begin
        if (y == '0) return {1'b1, x};
        if (ovf) return {1'b0, 32'h0};
        r = xs % ys;
        return {1'b0, r};
      end
      default: begin
        if (y == '0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, x / y};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with result 0x%08h, required no done", result);
      end else begin
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("dz", {31'd0, dz}, {31'd0, e.dz});
        chk("done_latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, guard);
    end
  endtask

  // Returns at the negedge after the start edge E0, with inputs scrambled.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] m;
    wait_idle();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom_range(3));
    a     = $urandom;
    b     = $urandom;
    m     = model(o, x, y);
    e.res = m[W-1:0];
    e.dz  = m[W];
    e.cyc = cyc + 32'd34;
    sb_q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int g;
    int ds;
    logic [1:0]   ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_dz", {31'd0, dz}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // MUL 7*6 with busy-length and hold checks.
    do_op(OP_MUL, 32'd7, 32'd6);
    n = 0;
    g = 0;
    while (!done && g < 100) begin
      if (busy) n++;
      @(negedge clk);
      g++;
    end
    chk("mul_busy_cycles", 32'(n), 32'd34);
    chk("busy_in_done_cycle", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    chk("result_held", result, 32'd42);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2);
    do_op(OP_MOD,  32'hFFFF_FFF9, 32'd2);
    do_op(OP_MOD,  32'd7,         32'hFFFF_FFFE);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2);
    do_op(OP_DIV,  32'hFFFF_FFFF, 32'd2);
    do_op(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(OP_DIV,  32'd5,         32'd0);
    do_op(OP_MOD,  32'd5,         32'd0);
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    do_op(OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF);
    do_op(OP_DIVU, 32'd5,         32'd0);

    // Start pulse while busy must be ignored; next op follows back-to-back.
    do_op(OP_MUL, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd9;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    do_op(OP_DIVU, 32'd100, 32'd7);

    // Reset mid-operation aborts without a done pulse.
    wait_idle();
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd1000;
    b     = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_dz", {31'd0, dz}, 32'd0);
    reset_n = 1'b1;
    ds = done_seen;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(done_seen - ds), 32'd0);
    do_op(OP_DIV, 32'd1000, 32'd7);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(3));
      case ($urandom_range(5))
        0: rx = 32'h8000_0000;
        1: rx = 32'($signed($urandom_range(40)) - 20);
        default: rx = $urandom;
      endcase
      case ($urandom_range(9))
        0: ry = 32'd0;
        1: ry = 32'hFFFF_FFFF;
        2: ry = 32'($urandom_range(15, 1));
        3: ry = 32'($signed($urandom_range(30)) - 15);
        default: ry = $urandom;
      endcase
      do_op(ro, rx, ry);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
